// File: rtl/register_operand_fetch.sv
`timescale 1ns/1ps
// register_operand_fetch
//
// This is the operand-fetch stage that sits directly after the register file.
// It takes one decoded instruction and picks operands A and B out of the
// flattened register file bus. It then registers them, together with the
// decode fields, for the execute stage.
//
// A per-register pending scoreboard tracks destinations that have been issued
// but not yet written back. An instruction that reads or writes a pending
// register is held (RAW / WAW) until the matching writeback strobe arrives.
//
// Optional feature (define the macro OPFETCH_FWD_EN):
//   - A source register that is being written back in the current cycle takes
//     wb_data directly and is treated as not pending (same-cycle bypass).
//   - Without the macro, the instruction stays stalled through the writeback
//     cycle. It issues one cycle later and reads the updated reg_data.
//
// Ports
//   clk, rst         clock; asynchronous active-high reset
//   in_valid/ready   decoded-instruction handshake
//   in_rs_a/b, in_rd source and destination register indices
//   in_wr_en, in_tag write flag and opaque payload
//   reg_data         register file read bus, reg i at [16i+15:16i]
//   wb_en, wb_data   writeback strobe (one bit per register) and its data
//   out_valid/ready  operand handshake toward execute
//   out_a/b, out_rd, out_wr_en, out_tag   registered operands and fields
//   stall_cycles     saturating count of cycles lost to hazards
module register_operand_fetch #(
  parameter int REGISTER_COUNT = 16,
  parameter int TAG_W          = 8,
  localparam int IDX_W         = (REGISTER_COUNT > 1) ? $clog2(REGISTER_COUNT) : 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [IDX_W-1:0]             in_rs_a,
  input  logic [IDX_W-1:0]             in_rs_b,
  input  logic [IDX_W-1:0]             in_rd,
  input  logic                         in_wr_en,
  input  logic [TAG_W-1:0]             in_tag,
  input  logic [16*REGISTER_COUNT-1:0] reg_data,
  input  logic [REGISTER_COUNT-1:0]    wb_en,
  input  logic [15:0]                  wb_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [15:0]                  out_a,
  output logic [15:0]                  out_b,
  output logic [IDX_W-1:0]             out_rd,
  output logic                         out_wr_en,
  output logic [TAG_W-1:0]             out_tag,
  output logic [15:0]                  stall_cycles
);

  localparam int DATA_W = 16;

  // Any index outside 0..REGISTER_COUNT-1 matches no entry, so it reads as 0
  // and is never reported as pending.
  function automatic logic [DATA_W-1:0] read_reg(
    input logic [IDX_W-1:0]                 idx,
    input logic [DATA_W*REGISTER_COUNT-1:0] regs
  );
    logic [DATA_W-1:0] val;
    val = '0;
    for (int i = 0; i < REGISTER_COUNT; i++)
      if (int'(idx) == i) val = regs[DATA_W*i +: DATA_W];
    return val;
  endfunction

  function automatic logic bit_of(
    input logic [IDX_W-1:0]          idx,
    input logic [REGISTER_COUNT-1:0] vec
  );
    logic b;
    b = 1'b0;
    for (int i = 0; i < REGISTER_COUNT; i++)
      if (int'(idx) == i) b = vec[i];
    return b;
  endfunction

  function automatic logic [REGISTER_COUNT-1:0] onehot(input logic [IDX_W-1:0] idx);
    logic [REGISTER_COUNT-1:0] oh;
    oh = '0;
    for (int i = 0; i < REGISTER_COUNT; i++)
      if (int'(idx) == i) oh[i] = 1'b1;
    return oh;
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [REGISTER_COUNT-1:0] pending;
  logic [DATA_W-1:0]         op_a_p0;
  logic [DATA_W-1:0]         op_b_p0;
  logic                      pend_a;
  logic                      pend_b;
  logic                      hazard;
  logic                      accept;

  always_comb begin
    op_a_p0 = read_reg(in_rs_a, reg_data);
    op_b_p0 = read_reg(in_rs_b, reg_data);
    pend_a  = bit_of(in_rs_a, pending);
    pend_b  = bit_of(in_rs_b, pending);
`ifdef OPFETCH_FWD_EN
    // A source written this cycle is taken from the writeback bus and no
    // longer blocks. The destination check below stays unmasked.
    if (bit_of(in_rs_a, wb_en)) begin
      op_a_p0 = wb_data;
      pend_a  = 1'b0;
    end
    if (bit_of(in_rs_b, wb_en)) begin
      op_b_p0 = wb_data;
      pend_b  = 1'b0;
    end
`endif
  end

`ifndef OPFETCH_FWD_EN
  // Without the bypass, wb_data is only consumed by the register file itself.
  logic unused_wb_data;
  assign unused_wb_data = ^wb_data;
`endif

  assign hazard   = pend_a | pend_b | (in_wr_en & bit_of(in_rd, pending));
  assign in_ready = (!out_valid | out_ready) & !hazard;
  assign accept   = in_valid & in_ready;

  // ---- stage boundary: fetched operands -> execute-facing registers ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid    <= 1'b0;
      out_a        <= '0;
      out_b        <= '0;
      out_rd       <= '0;
      out_wr_en    <= 1'b0;
      out_tag      <= '0;
      pending      <= '0;
      stall_cycles <= '0;
    end else begin
      if (accept) begin
        out_valid <= 1'b1;
        out_a     <= op_a_p0;
        out_b     <= op_b_p0;
        out_rd    <= in_rd;
        out_wr_en <= in_wr_en;
        out_tag   <= in_tag;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      // The set is applied after the clear, so a bit being both issued and
      // written back in the same cycle ends up set.
      pending <= (pending & ~wb_en) |
                 ((accept & in_wr_en) ? onehot(in_rd) : '0);
      if (in_valid & hazard)
        stall_cycles <= sat_inc(stall_cycles);
    end
  end

endmodule
